// File: rtl/tp84_snd_mixer.sv
// ----------------------------------------------------------------------------
// tp84_snd_mixer
//
// Sample-rate mixer for the tp84 sound path. Four unsigned 8-bit sources
// (three SN76489 voices plus the DAC) are each re-centred around 128, scaled
// by their own unsigned 8-bit gain, summed, shifted down and saturated into a
// single signed 16-bit sample. One sample is produced every DIV clocks. The
// single multiplier is time-shared across the four channels by a short FSM
// that runs once per sample period.
//
// Parameters
//   DIV    clocks per output sample, 8..1023 (256 -> 192 kHz at 49.152 MHz)
//   SHIFT  arithmetic right shift applied to the 19-bit sum, 0..3
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-low reset
//   ch_in      in   32  ch0 = [7:0] .. ch3 = [31:24], unsigned, 128 = silence
//   gain_in    in   32  gains packed in the same order, 255 = ~unity
//   out        out  16  signed mixed sample, held between strobes
//   out_valid  out  1   one-cycle strobe when out updates
//   clip       out  1   sticky saturation flag, only when
//                       TP84_MIX_CLIP_FLAG_EN is defined
//
// Build option
//   TP84_MIX_CLIP_FLAG_EN  adds the clip port and its sticky flag register.
//                          Saturation itself is identical either way.
// ----------------------------------------------------------------------------

module tp84_snd_mixer #(
    parameter int unsigned DIV   = 256,
    parameter int unsigned SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ch_in,
    input  logic [31:0] gain_in,
    output logic [15:0] out,
    output logic        out_valid
`ifdef TP84_MIX_CLIP_FLAG_EN
    ,
    output logic        clip
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [9:0] DIV_LAST = 10'(DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_ACC0  = 3'd2;
    localparam logic [2:0] S_ACC1  = 3'd3;
    localparam logic [2:0] S_ACC2  = 3'd4;
    localparam logic [2:0] S_ACC3  = 3'd5;
    localparam logic [2:0] S_SAT   = 3'd6;

    localparam logic signed [18:0] SAT_MAX = 19'sd32767;
    localparam logic signed [18:0] SAT_MIN = -19'sd32768;

    // ------------------------------------------------------------------------
    // Sample-rate divider
    // ------------------------------------------------------------------------
    logic [9:0] r_div_cnt;
    logic       w_tick;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= 10'd0;
        end else if (w_tick) begin
            r_div_cnt <= 10'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;

    // A tick outside IDLE is simply ignored; with DIV >= 8 the sequence has
    // always returned to IDLE before the next tick arrives.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = S_ACC0;
            S_ACC0:  w_state_nxt = S_ACC1;
            S_ACC1:  w_state_nxt = S_ACC2;
            S_ACC2:  w_state_nxt = S_ACC3;
            S_ACC3:  w_state_nxt = S_SAT;
            S_SAT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Input shadow registers
    // ------------------------------------------------------------------------
    // Snapshotting both buses in LATCH keeps the sample in flight coherent even
    // if the sound chips update their levels during the accumulate steps.
    logic [31:0] r_ch_sh;
    logic [31:0] r_gain_sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ch_sh   <= 32'd0;
            r_gain_sh <= 32'd0;
        end else if (r_state == S_LATCH) begin
            r_ch_sh   <= ch_in;
            r_gain_sh <= gain_in;
        end
    end

    // ------------------------------------------------------------------------
    // Shared multiplier
    // ------------------------------------------------------------------------
    logic [7:0]         w_ch_sel;
    logic [7:0]         w_gain_sel;
    logic signed [8:0]  w_sample;
    logic signed [8:0]  w_gain_s;
    logic signed [17:0] w_prod;
    logic signed [18:0] w_prod_ext;

    always_comb begin
        w_ch_sel   = r_ch_sh[7:0];
        w_gain_sel = r_gain_sh[7:0];
        case (r_state)
            S_ACC1: begin
                w_ch_sel   = r_ch_sh[15:8];
                w_gain_sel = r_gain_sh[15:8];
            end
            S_ACC2: begin
                w_ch_sel   = r_ch_sh[23:16];
                w_gain_sel = r_gain_sh[23:16];
            end
            S_ACC3: begin
                w_ch_sel   = r_ch_sh[31:24];
                w_gain_sel = r_gain_sh[31:24];
            end
            default: begin
                w_ch_sel   = r_ch_sh[7:0];
                w_gain_sel = r_gain_sh[7:0];
            end
        endcase
    end

    // Re-centre the unsigned source on 128: range -128..127.
    assign w_sample   = $signed({1'b0, w_ch_sel}) - 9'sd128;
    assign w_gain_s   = $signed({1'b0, w_gain_sel});
    // Product range -32640..32385; a gain of 0 yields exactly 0.
    assign w_prod     = w_sample * w_gain_s;
    assign w_prod_ext = {w_prod[17], w_prod};

    // ------------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------------
    // Four worst-case products span -130560..129540, inside 19 bits signed,
    // so no overflow handling is needed here.
    logic signed [18:0] r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= 19'sd0;
        end else begin
            case (r_state)
                S_LATCH: r_acc <= 19'sd0;
                S_ACC0,
                S_ACC1,
                S_ACC2,
                S_ACC3:  r_acc <= r_acc + w_prod_ext;
                default: r_acc <= r_acc;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Shift and saturate
    // ------------------------------------------------------------------------
    logic signed [18:0] w_shifted;
    logic               w_over;
    logic               w_under;
    logic [15:0]        w_sat;

    assign w_shifted = r_acc >>> SHIFT;
    assign w_over    = (w_shifted > SAT_MAX);
    assign w_under   = (w_shifted < SAT_MIN);

    always_comb begin
        if (w_over) begin
            w_sat = 16'h7fff;
        end else if (w_under) begin
            w_sat = 16'h8000;
        end else begin
            w_sat = w_shifted[15:0];
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    logic [15:0] r_out;
    logic        r_out_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out       <= 16'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == S_SAT);
            if (r_state == S_SAT) begin
                r_out <= w_sat;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

`ifdef TP84_MIX_CLIP_FLAG_EN
    // Sticky: once either rail has been hit it stays set until reset.
    logic r_clip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clip <= 1'b0;
        end else if ((r_state == S_SAT) && (w_over || w_under)) begin
            r_clip <= 1'b1;
        end
    end

    assign clip = r_clip;
`endif

endmodule

// File: tb/tb_tp84_snd_mixer.sv
// ----------------------------------------------------------------------------
// tb_tp84_snd_mixer
//
// Drives two mixer instances from the same inputs, one with SHIFT=2 and one
// with SHIFT=0, and compares every strobed sample against expected values
// from a table and from an arithmetic reference model. Also covers strobe
// spacing, output hold, the LATCH snapshot point and mid-sequence reset.
// Build with TP84_MIX_CLIP_FLAG_EN defined to also check the clip flags.
// ----------------------------------------------------------------------------

module tb_tp84_snd_mixer;

    localparam int DIV = 256;
    localparam int NV  = 27;

    logic        clk;
    logic        reset;
    logic [31:0] ch_in;
    logic [31:0] gain_in;
    logic [15:0] out2;
    logic [15:0] out0;
    logic        vld2;
    logic        vld0;
`ifdef TP84_MIX_CLIP_FLAG_EN
    logic        clip2;
    logic        clip0;
`endif

    tp84_snd_mixer #(.DIV(DIV), .SHIFT(2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .ch_in     (ch_in),
        .gain_in   (gain_in),
        .out       (out2),
        .out_valid (vld2)
`ifdef TP84_MIX_CLIP_FLAG_EN
        ,
        .clip      (clip2)
`endif
    );

    tp84_snd_mixer #(.DIV(DIV), .SHIFT(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .ch_in     (ch_in),
        .gain_in   (gain_in),
        .out       (out0),
        .out_valid (vld0)
`ifdef TP84_MIX_CLIP_FLAG_EN
        ,
        .clip      (clip0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ch;
        logic [31:0] gain;
        int          exp2;
        int          exp0;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Reference: weighted sum of re-centred sources, floor-divided by 2^sh.
    function automatic int mix_raw(input logic [31:0] ch, input logic [31:0] g, input int sh);
        int sum;
        int c;
        int k;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            c = int'(ch[i*8 +: 8]);
            k = int'(g[i*8 +: 8]);
            sum += (c - 128) * k;
        end
        return sum >>> sh;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit clips(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Wait for the next strobe on the SHIFT=2 instance; returns at #1 after
    // the strobing edge with the number of edges waited, or -1 on timeout.
    task automatic wait_strobe(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!vld2 && n < budget);
        if (!vld2) n = -1;
    endtask

    int  n;
    bit  exp_clip2;
    bit  exp_clip0;
    int  held;

    initial begin
        // Directed entries with hand-derived results.
        vecs[0] = '{32'h80808080, 32'hffffffff, 0, 0};
        vecs[1] = '{32'h808080ff, 32'hffffffff, 8096, 32385};
        vecs[2] = '{32'h80808000, 32'hffffffff, -8160, -32640};
        vecs[3] = '{32'h8080c880, 32'h00006400, 1800, 7200};
        vecs[4] = '{32'h12ff00ab, 32'h00000000, 0, 0};
        vecs[5] = '{32'hffffffff, 32'hffffffff, 32385, 32767};
        vecs[6] = '{32'h00000000, 32'hffffffff, -32640, -32768};
        for (int i = 7; i < NV; i++) begin
            logic [31:0] g;
            g = $urandom;
            if ($urandom_range(0, 2) == 0) g[8 +: 8] = 8'd0;
            if ($urandom_range(0, 3) == 0) g = g | 32'hff00_00ff;
            vecs[i].ch   = $urandom;
            vecs[i].gain = g;
            vecs[i].exp2 = clamp16(mix_raw(vecs[i].ch, g, 2));
            vecs[i].exp0 = clamp16(mix_raw(vecs[i].ch, g, 0));
        end

        // Reset state.
        reset   = 1'b0;
        ch_in   = 32'h80808080;
        gain_in = 32'hffffffff;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out2", s16(out2), 0);
        chk("reset_out0", s16(out0), 0);
        chk("reset_vld", int'(vld2) + int'(vld0), 0);
`ifdef TP84_MIX_CLIP_FLAG_EN
        chk("reset_clip", int'(clip2) + int'(clip0), 0);
`endif
        exp_clip2 = 1'b0;
        exp_clip0 = 1'b0;

        // First strobe latency after release.
        @(negedge clk);
        reset = 1'b1;
        wait_strobe(DIV + 20, n);
        chk("first_strobe_latency", n, DIV + 6);
        chk("first_out_silence", s16(out2), 0);

        // Table-driven sample checks.
        for (int i = 0; i < NV; i++) begin
            ch_in   = vecs[i].ch;
            gain_in = vecs[i].gain;
            @(posedge clk);
            #1;
            chk($sformatf("pulse_width[%0d]", i), int'(vld2) + int'(vld0), 0);
            held = s16(out2);
            repeat (100) @(posedge clk);
            #1;
            chk($sformatf("out_held[%0d]", i), s16(out2), held);
            wait_strobe(DIV, n);
            chk($sformatf("spacing[%0d]", i), n, DIV - 101);
            chk($sformatf("vld0_together[%0d]", i), int'(vld0), 1);
            chk($sformatf("out_shift2[%0d]", i), s16(out2), vecs[i].exp2);
            chk($sformatf("out_shift0[%0d]", i), s16(out0), vecs[i].exp0);
            if (clips(mix_raw(vecs[i].ch, vecs[i].gain, 2))) exp_clip2 = 1'b1;
            if (clips(mix_raw(vecs[i].ch, vecs[i].gain, 0))) exp_clip0 = 1'b1;
`ifdef TP84_MIX_CLIP_FLAG_EN
            chk($sformatf("clip_shift2[%0d]", i), int'(clip2), int'(exp_clip2));
            chk($sformatf("clip_shift0[%0d]", i), int'(clip0), int'(exp_clip0));
`endif
        end

        // Inputs changed one cycle after LATCH affect only the following sample.
        ch_in   = 32'h808080ff;
        gain_in = 32'hffffffff;
        wait_strobe(DIV + 20, n);
        chk("pre_latch_out", s16(out2), 8096);
        repeat (DIV - 5) @(posedge clk);
        #1;
        ch_in = 32'h00000000;
        wait_strobe(DIV + 20, n);
        chk("latch_to_strobe", n, 5);
        chk("inflight_old_value", s16(out2), 8096);
        wait_strobe(DIV + 20, n);
        chk("next_sample_spacing", n, DIV);
        chk("next_sample_new_value", s16(out2), -32640);

        // Reset during ACC2 aborts the sample in flight.
        ch_in = 32'h808080ff;
        wait_strobe(DIV + 20, n);
        chk("before_reset_out", s16(out2), 8096);
        repeat (DIV - 3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_out2", s16(out2), 0);
        chk("abort_out0", s16(out0), 0);
        chk("abort_vld", int'(vld2) + int'(vld0), 0);
`ifdef TP84_MIX_CLIP_FLAG_EN
        chk("abort_clip0", int'(clip0), 0);
`endif
        repeat (4) @(posedge clk);
        #1;
        chk("no_strobe_in_reset", int'(vld2) + int'(vld0), 0);
        @(negedge clk);
        reset = 1'b1;
        wait_strobe(DIV + 20, n);
        chk("restart_latency", n, DIV + 6);
        chk("restart_out", s16(out2), 8096);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
